// File: rtl/alu_wb_scheduler_if.sv
// Issue/writeback bundle between decode and the execute-stage scheduler.
// The master modport is the decode side; the slave modport is the scheduler.
interface alu_wb_scheduler_if #(
   parameter int unsigned REG_ADDR    = 5,
   parameter int unsigned MUL_LATENCY = 5
);
   logic                   issue_valid;
   logic                   issue_is_mul;
   logic                   issue_writes_rd;
   logic [REG_ADDR-1:0]    issue_rd;
   logic [REG_ADDR-1:0]    issue_rs1;
   logic [REG_ADDR-1:0]    issue_rs2;
   logic                   issue_rs1_used;
   logic                   issue_rs2_used;
   logic                   flush;
   logic                   stall;
   logic                   issue_accept;
   logic [MUL_LATENCY-2:0] mul_stage_valid;
   logic                   wb_valid;
   logic [REG_ADDR-1:0]    wb_rd;
   logic                   wb_from_mul;
   logic                   busy;

   modport master (
      output issue_valid, issue_is_mul, issue_writes_rd, issue_rd, issue_rs1, issue_rs2,
             issue_rs1_used, issue_rs2_used, flush,
      input  stall, issue_accept, mul_stage_valid, wb_valid, wb_rd, wb_from_mul, busy
   );

   modport slave (
      input  issue_valid, issue_is_mul, issue_writes_rd, issue_rd, issue_rs1, issue_rs2,
             issue_rs1_used, issue_rs2_used, flush,
      output stall, issue_accept, mul_stage_valid, wb_valid, wb_rd, wb_from_mul, busy
   );
endinterface

// File: rtl/alu_wb_scheduler.sv
// Shares the regfile writeback port between the 1-cycle ALU and the pipelined MUL,
// stalling issue on port collisions and RAW/WAW hazards against in-flight MULs.
// Optional perf counters (stall_cycles_o, mul_issued_o) enabled by ALU_WB_SCHED_PERF_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module alu_wb_scheduler #(
   parameter int unsigned WORD_SIZE   = `WORD_SIZE,
   parameter int unsigned MUL_LATENCY = 5,
   parameter int unsigned REG_ADDR    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_wb_scheduler_if.slave    bus
`ifdef ALU_WB_SCHED_PERF_EN
   ,
   output logic [WORD_SIZE-1:0] stall_cycles_o,
   output logic [WORD_SIZE-1:0] mul_issued_o
`endif
);

   localparam int unsigned NSTG = MUL_LATENCY - 1;
   localparam int unsigned LAST = NSTG - 1;

   generate
      if (MUL_LATENCY < 2 || WORD_SIZE == 0) begin : g_bad_param
         $error("alu_wb_scheduler: MUL_LATENCY must be >= 2 and WORD_SIZE > 0");
      end
   endgenerate

   typedef struct packed {
      logic                valid;
      logic [REG_ADDR-1:0] rd;
   } stage_t;

   stage_t              stg_q [NSTG];
   stage_t              stg_d [NSTG];
   logic                wb_valid_q, wb_valid_d;
   logic                wb_from_mul_q, wb_from_mul_d;
   logic [REG_ADDR-1:0] wb_rd_q, wb_rd_d;
   logic [NSTG-1:0]     stage_valid;
   logic                hazard_c, collide_c, stall_c, accept_c, alu_wb_c;

   // Hazard detection against every pending MUL destination.
   always_comb begin
      hazard_c = 1'b0;
      for (int unsigned k = 0; k < NSTG; k++) begin
         if (stg_q[k].valid) begin
            if (bus.issue_rs1_used && bus.issue_rs1 != '0 && bus.issue_rs1 == stg_q[k].rd)
               hazard_c = 1'b1;
            if (bus.issue_rs2_used && bus.issue_rs2 != '0 && bus.issue_rs2 == stg_q[k].rd)
               hazard_c = 1'b1;
            if (bus.issue_writes_rd && bus.issue_rd != '0 && bus.issue_rd == stg_q[k].rd)
               hazard_c = 1'b1;
         end
      end
      // The oldest stage owns next cycle's writeback slot.
      collide_c = ~bus.issue_is_mul & bus.issue_writes_rd & stg_q[LAST].valid;
      stall_c   = bus.issue_valid & ~bus.flush & (hazard_c | collide_c);
      accept_c  = bus.issue_valid & ~bus.flush & ~stall_c;
      alu_wb_c  = accept_c & ~bus.issue_is_mul & bus.issue_writes_rd;
   end

   // Tracker shift and writeback selection.
   always_comb begin
      stg_d[0].valid = accept_c & bus.issue_is_mul;
      stg_d[0].rd    = bus.issue_rd;
      for (int unsigned k = 1; k < NSTG; k++) begin
         stg_d[k] = stg_q[k-1];
      end
      wb_valid_d    = stg_q[LAST].valid | alu_wb_c;
      wb_from_mul_d = stg_q[LAST].valid;
      wb_rd_d       = wb_rd_q;
      if (stg_q[LAST].valid) begin
         wb_rd_d = stg_q[LAST].rd;
      end else if (alu_wb_c) begin
         wb_rd_d = bus.issue_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NSTG; k++) begin
            stg_q[k] <= '0;
         end
         wb_valid_q    <= 1'b0;
         wb_from_mul_q <= 1'b0;
         wb_rd_q       <= '0;
      end else begin
         for (int unsigned k = 0; k < NSTG; k++) begin
            stg_q[k] <= stg_d[k];
         end
         wb_valid_q    <= wb_valid_d;
         wb_from_mul_q <= wb_from_mul_d;
         wb_rd_q       <= wb_rd_d;
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NSTG; k++) begin
         stage_valid[k] = stg_q[k].valid;
      end
   end

   assign bus.stall           = stall_c;
   assign bus.issue_accept    = accept_c;
   assign bus.mul_stage_valid = stage_valid;
   assign bus.busy            = |stage_valid;
   assign bus.wb_valid        = wb_valid_q;
   assign bus.wb_rd           = wb_rd_q;
   assign bus.wb_from_mul     = wb_from_mul_q;

`ifdef ALU_WB_SCHED_PERF_EN
   logic [WORD_SIZE-1:0] stall_cnt_q, mul_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         mul_cnt_q   <= '0;
      end else begin
         if (stall_c && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + WORD_SIZE'(1);
         if (accept_c && bus.issue_is_mul && mul_cnt_q != '1) mul_cnt_q <= mul_cnt_q + WORD_SIZE'(1);
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign mul_issued_o   = mul_cnt_q;
`endif

endmodule

// File: tb/tb_alu_wb_scheduler.sv
// Directed bench for alu_wb_scheduler (MUL_LATENCY=5): a per-cycle vector table
// plus hand sequences for reset behaviour.
module tb_alu_wb_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_wb_scheduler_if #(.REG_ADDR(5), .MUL_LATENCY(5)) bus ();

`ifdef ALU_WB_SCHED_PERF_EN
   logic [31:0] stall_cycles, mul_issued;
`endif

   alu_wb_scheduler #(.WORD_SIZE(32), .MUL_LATENCY(5), .REG_ADDR(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ALU_WB_SCHED_PERF_EN
      ,
      .stall_cycles_o (stall_cycles),
      .mul_issued_o   (mul_issued)
`endif
   );

   typedef struct {
      logic       v, m, w;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, fl;
      logic       st, ac, wv;
      logic [4:0] wrd;
      logic       wfm;
      logic [3:0] msv;
   } row_t;

   row_t rows[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input int v, m, w, rd, rs1, rs2, u1, u2, fl,
                      input int st, ac, wv, wrd, wfm, msv);
      row_t r;
      r.v = 1'(v);   r.m = 1'(m);     r.w = 1'(w);
      r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      r.u1 = 1'(u1); r.u2 = 1'(u2);   r.fl = 1'(fl);
      r.st = 1'(st); r.ac = 1'(ac);   r.wv = 1'(wv);
      r.wrd = 5'(wrd); r.wfm = 1'(wfm); r.msv = 4'(msv);
      rows.push_back(r);
   endtask

   task automatic idle(input int wv, wrd, wfm, msv);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wv, wrd, wfm, msv);
   endtask

   task automatic chk(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic drive(input row_t r);
      bus.issue_valid     = r.v;
      bus.issue_is_mul    = r.m;
      bus.issue_writes_rd = r.w;
      bus.issue_rd        = r.rd;
      bus.issue_rs1       = r.rs1;
      bus.issue_rs2       = r.rs2;
      bus.issue_rs1_used  = r.u1;
      bus.issue_rs2_used  = r.u2;
      bus.flush           = r.fl;
   endtask

   task automatic check_row(input int i, input row_t r);
      chk($sformatf("row%0d stall", i), int'(bus.stall), int'(r.st));
      chk($sformatf("row%0d accept", i), int'(bus.issue_accept), int'(r.ac));
      chk($sformatf("row%0d wb_valid", i), int'(bus.wb_valid), int'(r.wv));
      if (r.wv) begin
         chk($sformatf("row%0d wb_rd", i), int'(bus.wb_rd), int'(r.wrd));
         chk($sformatf("row%0d wb_from_mul", i), int'(bus.wb_from_mul), int'(r.wfm));
      end
      chk($sformatf("row%0d mul_stage_valid", i), int'(bus.mul_stage_valid), int'(r.msv));
      chk($sformatf("row%0d busy", i), int'(bus.busy), int'(r.msv != 4'b0000));
   endtask

   initial begin
      row_t z;
      z = '{default: '0};
      // Vector columns: v m w rd rs1 rs2 u1 u2 fl | stall accept wb_valid wb_rd wb_from_mul msv
      idle(0, 0, 0, 'b0000);
      add(1,0,1, 3, 1,2, 1,1,0,  0,1, 0,0,0, 'b0000);   // ADD x3
      idle(1, 3, 0, 'b0000);
      add(1,1,1, 5, 1,2, 1,1,0,  0,1, 0,0,0, 'b0000);   // MUL x5
      idle(0, 0, 0, 'b0001);
      idle(0, 0, 0, 'b0010);
      add(1,0,1, 6, 1,2, 1,1,0,  0,1, 0,0,0, 'b0100);   // ADD x6, MUL not yet in last stage
      add(1,0,1, 9, 1,2, 1,1,0,  1,0, 1,6,0, 'b1000);   // ADD x9 collides with MUL slot
      add(1,0,1, 9, 1,2, 1,1,0,  0,1, 1,5,1, 'b0000);   // accepted while MUL writes back
      idle(1, 9, 0, 'b0000);
      add(1,1,1, 7, 0,0, 0,0,0,  0,1, 0,0,0, 'b0000);   // MUL x7
      add(1,0,1, 2, 7,0, 1,0,0,  1,0, 0,0,0, 'b0001);   // RAW on x7
      add(1,0,1, 2, 7,0, 1,0,0,  1,0, 0,0,0, 'b0010);
      add(1,0,1, 2, 7,0, 1,0,0,  1,0, 0,0,0, 'b0100);
      add(1,0,1, 2, 7,0, 1,0,0,  1,0, 0,0,0, 'b1000);
      add(1,0,1, 2, 7,0, 1,0,0,  0,1, 1,7,1, 'b0000);
      idle(1, 2, 0, 'b0000);
      add(1,1,1, 7, 0,0, 0,0,0,  0,1, 0,0,0, 'b0000);   // MUL x7
      add(1,0,1, 0, 7,0, 1,0,0,  1,0, 0,0,0, 'b0001);   // SUB x0 <- x7
      add(1,0,1, 0, 7,0, 1,0,0,  1,0, 0,0,0, 'b0010);
      add(1,0,1, 0, 7,0, 1,0,0,  1,0, 0,0,0, 'b0100);
      add(1,0,1, 0, 7,0, 1,0,0,  1,0, 0,0,0, 'b1000);
      add(1,0,1, 0, 7,0, 1,0,0,  0,1, 1,7,1, 'b0000);
      idle(1, 0, 0, 'b0000);                            // x0 write still uses the port
      add(1,1,1, 4, 0,0, 0,0,0,  0,1, 0,0,0, 'b0000);   // MUL x4
      add(1,0,1, 4, 4,0, 0,0,0,  1,0, 0,0,0, 'b0001);   // WAW, rs1 unused
      add(1,1,1, 4, 0,0, 0,0,0,  1,0, 0,0,0, 'b0010);   // MUL WAW
      add(1,1,1,10, 0,4, 0,1,0,  1,0, 0,0,0, 'b0100);   // MUL RAW via rs2
      add(1,0,1, 0, 0,0, 1,0,0,  1,0, 0,0,0, 'b1000);   // x0 ALU write collides
      idle(1, 4, 1, 'b0000);
      idle(0, 0, 0, 'b0000);
      add(1,1,1, 0, 0,0, 0,0,0,  0,1, 0,0,0, 'b0000);   // MUL x0
      add(1,0,1,11, 0,0, 1,1,0,  0,1, 0,0,0, 'b0001);   // reads x0: no hazard
      idle(1,11, 0, 'b0010);
      idle(0, 0, 0, 'b0100);
      idle(0, 0, 0, 'b1000);
      idle(1, 0, 1, 'b0000);
      add(1,0,0, 0, 3,4, 1,1,0,  0,1, 0,0,0, 'b0000);   // BEQ: no writeback
      idle(0, 0, 0, 'b0000);
      add(1,1,1, 8, 0,0, 0,0,0,  0,1, 0,0,0, 'b0000);   // MUL x8
      add(0,0,1, 8, 8,0, 1,0,0,  0,0, 0,0,0, 'b0001);   // invalid: never stalls
      add(1,0,0, 0, 8,0, 1,0,1,  0,0, 0,0,0, 'b0010);   // flushed BEQ
      add(1,0,1,12, 8,0, 1,0,1,  0,0, 0,0,0, 'b0100);   // flushed ADD
      add(1,0,0, 0, 1,2, 1,1,0,  0,1, 0,0,0, 'b1000);   // non-writer never collides
      idle(1, 8, 1, 'b0000);
      idle(0, 0, 0, 'b0000);
      add(1,1,1,13, 0,0, 0,0,0,  0,1, 0,0,0, 'b0000);   // back-to-back MULs
      add(1,1,1,14, 0,0, 0,0,0,  0,1, 0,0,0, 'b0001);
      idle(0, 0, 0, 'b0011);
      idle(0, 0, 0, 'b0110);
      idle(0, 0, 0, 'b1100);
      idle(1,13, 1, 'b1000);
      idle(1,14, 1, 'b0000);
      idle(0, 0, 0, 'b0000);

      // Reset and idle after release.
      drive(z);
      #1 rst = 1'b1;
      #2;
      chk("reset wb_valid", int'(bus.wb_valid), 0);
      chk("reset wb_rd", int'(bus.wb_rd), 0);
      chk("reset wb_from_mul", int'(bus.wb_from_mul), 0);
      chk("reset mul_stage_valid", int'(bus.mul_stage_valid), 0);
      chk("reset busy", int'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("idle%0d wb_valid", i), int'(bus.wb_valid), 0);
         chk($sformatf("idle%0d busy", i), int'(bus.busy), 0);
         chk($sformatf("idle%0d stall", i), int'(bus.stall), 0);
      end

      for (int i = 0; i < rows.size(); i++) begin
         @(negedge clk);
         drive(rows[i]);
         #1;
         check_row(i, rows[i]);
      end

      // Reset in the middle of a MUL discards it.
      @(negedge clk);
      z.v = 1'b1; z.m = 1'b1; z.w = 1'b1; z.rd = 5'd5;
      drive(z);
      #1 chk("midrst accept", int'(bus.issue_accept), 1);
      z = '{default: '0};
      @(negedge clk);
      drive(z);
      @(negedge clk);
      #1 chk("midrst pre msv", int'(bus.mul_stage_valid), 'b0010);
      #1 rst = 1'b1;
      #1;
      chk("midrst msv", int'(bus.mul_stage_valid), 0);
      chk("midrst busy", int'(bus.busy), 0);
      chk("midrst wb_valid", int'(bus.wb_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("postrst%0d wb_valid", i), int'(bus.wb_valid), 0);
         chk($sformatf("postrst%0d msv", i), int'(bus.mul_stage_valid), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
